// File: rtl/program_loader.sv
// Boot loader for the UART word path: length header, N words into imem, then
// releases the CPU and routes later words into a show-ahead input FIFO.
module program_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           word,
    input  logic                  word_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_run,
    input  logic                  in_pop,
    output logic [31:0]           in_data,
    output logic                  in_empty,
    output logic                  len_error,
    output logic                  overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [31:0] MAX_WORDS32 = 32'(MAX_WORDS);

    typedef enum logic [1:0] {WAIT_LEN = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

    state_t                state_q, state_d;
    logic                  ready_q;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  len_err_q, len_err_d;
    logic                  ovf_q, ovf_d;
    logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]           mem_q [FIFO_DEPTH];
    logic                  new_word, full, empty, push_req, push_ok, pop_ok;

    assign new_word = word_ready & ~ready_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        len_err_d   = len_err_q;
        case (state_q)
            WAIT_LEN: begin
                if (new_word) begin
                    addr_d = '0;
                    if (word == 32'd0) begin
                        state_d = RUN;
                    end else if (word > MAX_WORDS32) begin
                        remaining_d = MAX_WORDS;
                        len_err_d   = 1'b1;
                        state_d     = LOAD;
                    end else begin
                        remaining_d = word[ADDR_WIDTH:0];
                        state_d     = LOAD;
                    end
                end
            end
            LOAD: begin
                // Leave one cycle after the last write so cpu_run trails the final pulse.
                if (remaining_q == '0) begin
                    state_d = RUN;
                end else if (new_word) begin
                    we_d        = 1'b1;
                    waddr_d     = addr_q;
                    wdata_d     = word;
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                end
            end
            RUN: ;
            default: state_d = WAIT_LEN;
        endcase
    end

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        push_req = new_word && (state_q == RUN);
        pop_ok   = in_pop && !empty;
        // A full FIFO still accepts a push when the head is popped in the same cycle.
        push_ok  = push_req && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ovf_d    = ovf_q | (push_req & full & ~pop_ok);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= WAIT_LEN;
            ready_q     <= 1'b1;
            remaining_q <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            len_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= word_ready;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            len_err_q   <= len_err_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && push_ok) mem_q[wr_ptr_q[PW-1:0]] <= word;
    end

    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_run    = (state_q == RUN);
    assign in_data    = mem_q[rd_ptr_q[PW-1:0]];
    assign in_empty   = empty;
    assign len_error  = len_err_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: header handling, imem writes, clamping,
// run-time FIFO boundaries and mid-load reset.
module tb_program_loader;
    localparam int AW = 14;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [31:0]   word = '0;
    logic          word_ready = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_run;
    logic          in_pop = 1'b0;
    logic [31:0]   in_data;
    logic          in_empty;
    logic          len_error;
    logic          overflow;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int base;
    bit prev_we = 1'b0;
    bit consec  = 1'b0;
    logic        got_we, got_run;
    logic [31:0] got_addr, got_data;

    program_loader #(.ADDR_WIDTH(AW), .FIFO_DEPTH(8)) dut (
        .CLK(CLK), .RST(RST), .word(word), .word_ready(word_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_run(cpu_run), .in_pop(in_pop), .in_data(in_data),
        .in_empty(in_empty), .len_error(len_error), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (imem_we && prev_we) consec = 1'b1;
        prev_we = imem_we;
        if (imem_we) we_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One rising edge on word_ready; snapshot outputs in the cycle after the edge.
    task automatic send_word(input logic [31:0] w);
        word = w;
        word_ready = 1'b1;
        tick();
        got_we   = imem_we;
        got_addr = 32'(imem_addr);
        got_data = imem_wdata;
        got_run  = cpu_run;
        word_ready = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        in_pop = 1'b1;
        tick();
        in_pop = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        word_ready = 1'b0;
        in_pop = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        tick();
    endtask

    initial begin
        // Reset with word_ready held high: the level must not count as a word.
        word = 32'd5;
        tick(); tick();
        RST = 1'b0;
        tick(); tick();
        chk("rst_we", imem_we, 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_run", cpu_run, 0);
        chk("rst_empty", in_empty, 1);
        chk("rst_lenerr", len_error, 0);
        chk("rst_ovf", overflow, 0);
        chk("held_no_pulse", we_cnt, 0);
        word_ready = 1'b0;
        tick();
        base = we_cnt;
        send_word(32'd2);
        chk("hdr2_no_we", got_we, 0);
        send_word(32'hB0000001);
        chk("hdr2_w0_addr", got_addr, 0);
        send_word(32'hB0000002);
        chk("hdr2_w1_addr", got_addr, 1);
        chk("hdr2_run", cpu_run, 1);
        chk("hdr2_cnt", we_cnt - base, 2);

        // Header 3
        do_reset();
        base = we_cnt;
        send_word(32'd3);
        send_word(32'hA0000001);
        chk("h3_we0", got_we, 1);
        chk("h3_addr0", got_addr, 0);
        chk("h3_data0", got_data, 32'hA0000001);
        send_word(32'hA0000002);
        chk("h3_addr1", got_addr, 1);
        chk("h3_data1", got_data, 32'hA0000002);
        send_word(32'hA0000003);
        chk("h3_addr2", got_addr, 2);
        chk("h3_data2", got_data, 32'hA0000003);
        chk("h3_run_during_pulse", got_run, 0);
        chk("h3_run_after", cpu_run, 1);
        chk("h3_cnt", we_cnt - base, 3);
        chk("h3_lenerr", len_error, 0);

        // Header 0 goes straight to RUN
        do_reset();
        base = we_cnt;
        send_word(32'd0);
        chk("h0_run", got_run, 1);
        chk("h0_no_we", we_cnt - base, 0);

        // Oversized header clamps to MAX_WORDS
        do_reset();
        base = we_cnt;
        send_word(32'h0001_0000);
        chk("big_lenerr", len_error, 1);
        for (int i = 0; i < 16384; i++) begin
            send_word(32'h5A5A0000 ^ 32'(i));
            if (i == 0) chk("big_first_addr", got_addr, 0);
            if (i == 16382) chk("big_run_early", cpu_run, 0);
        end
        chk("big_last_addr", got_addr, 16383);
        chk("big_last_data", got_data, 32'h5A5A0000 ^ 32'd16383);
        chk("big_run_mid", got_run, 0);
        chk("big_run", cpu_run, 1);
        chk("big_cnt", we_cnt - base, 16384);
        send_word(32'hCAFE0001);
        chk("big_post_no_we", got_we, 0);
        chk("big_post_fifo", in_empty, 0);
        chk("big_post_data", in_data, 32'hCAFE0001);

        // FIFO overflow and ordering
        do_reset();
        send_word(32'd0);
        send_word(32'h101);
        chk("f_nonempty", in_empty, 0);
        chk("f_head", in_data, 32'h101);
        for (int i = 2; i <= 8; i++) send_word(32'h100 + 32'(i));
        chk("f_ovf8", overflow, 0);
        send_word(32'h109);
        chk("f_ovf9", overflow, 1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("f_pop%0d", i), in_data, 32'h100 + 32'(i));
            pop_one();
        end
        chk("f_empty", in_empty, 1);
        pop_one();
        send_word(32'h200);
        chk("f_after_emptypop", in_data, 32'h200);
        pop_one();
        chk("f_empty2", in_empty, 1);
        chk("f_ovf_sticky", overflow, 1);

        // Full + push + pop same cycle
        do_reset();
        send_word(32'd0);
        for (int i = 1; i <= 8; i++) send_word(32'h300 + 32'(i));
        word = 32'h309;
        word_ready = 1'b1;
        in_pop = 1'b1;
        tick();
        in_pop = 1'b0;
        word_ready = 1'b0;
        tick();
        chk("fp_ovf", overflow, 0);
        for (int i = 2; i <= 9; i++) begin
            chk($sformatf("fp_pop%0d", i), in_data, 32'h300 + 32'(i));
            pop_one();
        end
        chk("fp_empty", in_empty, 1);

        // Push + pop same cycle while empty: pop ignored
        do_reset();
        send_word(32'd0);
        word = 32'h400;
        word_ready = 1'b1;
        in_pop = 1'b1;
        tick();
        in_pop = 1'b0;
        word_ready = 1'b0;
        tick();
        chk("ep_nonempty", in_empty, 0);
        chk("ep_data", in_data, 32'h400);

        // Reset mid-load, then reload from address 0
        do_reset();
        send_word(32'd3);
        send_word(32'hD0000001);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        chk("ml_run", cpu_run, 0);
        chk("ml_addr", 32'(imem_addr), 0);
        chk("ml_empty", in_empty, 1);
        send_word(32'd2);
        chk("ml_hdr_no_we", got_we, 0);
        send_word(32'hE0000001);
        chk("ml_we", got_we, 1);
        chk("ml_addr0", got_addr, 0);
        chk("ml_data0", got_data, 32'hE0000001);

        chk("we_never_consecutive", 32'(consec), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
